cam_pattern_gen: RTL and testbench



---
 rtl/cam_pattern_gen.sv | 172 +++++++++++++++++
 tb/tb_cam_pattern_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pattern_gen.sv
// OV7670-style sensor emulator: drives pclk/vsync/href/data with RGB555 test-pattern frames.
// All bus outputs change on the clk edge where pclk falls and hold through the next pclk rise.
module cam_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 784,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 17,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 510,
  parameter int unsigned BAR_W    = 80
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [1:0] pattern,
  output logic       pclk,
  output logic       vsync,
  output logic       href,
  output logic [7:0] data,
  output logic [7:0] frame_cnt
);

  localparam int unsigned HW = $clog2(2 * H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);
  localparam int unsigned BW = $clog2(BAR_W + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(2 * H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_B    = HW'(2 * H_ACTIVE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_LO   = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_HI   = VW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t        state, state_d;
  logic [HW-1:0] hcnt, hcnt_d;
  logic [VW-1:0] vcnt, vcnt_d;
  logic [1:0]    pat, pat_d;
  logic [7:0]    frame_cnt_d;
  logic [BW-1:0] bar_px, bar_px_d;
  logic [2:0]    bar_idx, bar_idx_d;
  logic          vsync_d, href_d;
  logic [7:0]    data_d;

  // State register; everything except pclk advances only on the pclk fall tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pclk      <= 1'b0;
      state     <= IDLE;
      hcnt      <= '0;
      vcnt      <= '0;
      pat       <= '0;
      bar_px    <= '0;
      bar_idx   <= '0;
      frame_cnt <= '0;
      vsync     <= 1'b0;
      href      <= 1'b0;
      data      <= 8'h00;
    end else begin
      pclk <= ~pclk;
      if (pclk) begin
        state     <= state_d;
        hcnt      <= hcnt_d;
        vcnt      <= vcnt_d;
        pat       <= pat_d;
        bar_px    <= bar_px_d;
        bar_idx   <= bar_idx_d;
        frame_cnt <= frame_cnt_d;
        vsync     <= vsync_d;
        href      <= href_d;
        data      <= data_d;
      end
    end
  end

  // Next raster position, evaluated as if this clk were a fall tick.
  always_comb begin
    logic start;
    state_d     = state;
    hcnt_d      = hcnt;
    vcnt_d      = vcnt;
    pat_d       = pat;
    frame_cnt_d = frame_cnt;
    bar_px_d    = bar_px;
    bar_idx_d   = bar_idx;
    start       = 1'b0;

    case (state)
      IDLE: start = en;
      FRAME: begin
        if (hcnt == H_LAST) begin
          hcnt_d = '0;
          if (vcnt == V_LAST) begin
            vcnt_d = '0;
            if (en) start = 1'b1;
            else state_d = IDLE;
          end else begin
            vcnt_d = vcnt + VW'(1);
          end
        end else begin
          hcnt_d = hcnt + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d     = FRAME;
      hcnt_d      = '0;
      vcnt_d      = '0;
      pat_d       = pattern;
      frame_cnt_d = frame_cnt + 8'd1;
    end

    // Bar index tracks col/BAR_W with a pixel counter, saturating at the last bar.
    if (hcnt_d == '0) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (!hcnt_d[0]) begin
      if (bar_px == BAR_LAST) begin
        bar_px_d = '0;
        if (bar_idx != 3'd7) bar_idx_d = bar_idx + 3'd1;
      end else begin
        bar_px_d = bar_px + BW'(1);
      end
    end
  end

  // Bus values for the next raster position.
  always_comb begin
    logic [15:0] col, row;
    logic [2:0]  c;
    logic [4:0]  r, g, b;
    logic        active, chk;
    col     = 16'(hcnt_d) >> 1;
    row     = 16'(vcnt_d) - 16'(V_SYNC + V_BACK);
    c       = 3'd7 - bar_idx_d;
    chk     = 1'(col >> 5) ^ 1'(row >> 5);
    active  = (vcnt_d >= V_ACT_LO) && (vcnt_d < V_ACT_HI);
    vsync_d = (state_d == FRAME) && (vcnt_d < V_SYNC_END);
    href_d  = (state_d == FRAME) && active && (hcnt_d < H_ACT_B);

    case (pat_d)
      2'd0: begin
        r = {5{c[2]}};
        g = {5{c[1]}};
        b = {5{c[0]}};
      end
      2'd1: begin
        r = {5{chk}};
        g = {5{chk}};
        b = {5{chk}};
      end
      2'd2: begin
        r = 5'(col >> 5);
        g = 5'(row >> 4);
        b = 5'(frame_cnt_d);
      end
      default: begin
        r = 5'd31;
        g = 5'd0;
        b = 5'd0;
      end
    endcase

    data_d = 8'h00;
    if (href_d) data_d = hcnt_d[0] ? {g[2:0], b} : {1'b0, r, g[4:3]};
  end

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Bench for cam_pattern_gen: frames are predicted as byte queues from the pattern rules,
// and a pclk-rate monitor checks timing and pops expected bytes whenever href is high.
module tb_cam_pattern_gen;

  localparam int HA = 80, HT = 84, VS = 2, VB = 1, VA = 34, VT = 38, TB_BAR = 8;
  localparam int LINE_B    = 2 * HT;
  localparam int FRAME_B   = LINE_B * VT;
  localparam int FRAME_CLK = 2 * FRAME_B;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic       pclk, vsync, href;
  logic [7:0] data, frame_cnt;

  cam_pattern_gen #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_SYNC(VS), .V_BACK(VB),
    .V_ACTIVE(VA), .V_TOTAL(VT), .BAR_W(TB_BAR)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .pattern(pattern),
    .pclk(pclk), .vsync(vsync), .href(href), .data(data), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;
    int fc;
    bit chained;
  } frame_t;

  frame_t     frame_q[$];
  logic [7:0] byte_q[$];
  int errors = 0, checks = 0;
  int frames_started = 0, frames_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pixel colour straight from the pattern definitions.
  function automatic logic [7:0] ref_byte(input int p, input int fc, input int col,
                                          input int row, input int half);
    int r, g, b, i, c;
    case (p)
      0: begin
        i = col / TB_BAR;
        if (i > 7) i = 7;
        c = 7 - i;
        r = (c & 4) != 0 ? 31 : 0;
        g = (c & 2) != 0 ? 31 : 0;
        b = (c & 1) != 0 ? 31 : 0;
      end
      1: begin
        r = ((col / 32 + row / 32) % 2 == 1) ? 31 : 0;
        g = r;
        b = r;
      end
      2: begin
        r = (col / 32) % 32;
        g = (row / 16) % 32;
        b = fc % 32;
      end
      default: begin
        r = 31; g = 0; b = 0;
      end
    endcase
    if (half == 0) return 8'(r * 4 + g / 8);
    return 8'((g % 8) * 32 + b);
  endfunction

  task automatic push_frame(input int p, input int fc, input bit chained);
    frame_t f;
    f.pat = p; f.fc = fc; f.chained = chained;
    frame_q.push_back(f);
    for (int row = 0; row < VA; row++)
      for (int col = 0; col < HA; col++) begin
        byte_q.push_back(ref_byte(p, fc, col, row, 0));
        byte_q.push_back(ref_byte(p, fc, col, row, 1));
      end
  endtask

  // Monitor: one sample per pclk period, half a clk after pclk rises.
  bit     busy = 0, must_start = 0;
  int     s = 0, line, bpos;
  frame_t cur;
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_q.delete();
      byte_q.delete();
      busy = 0; must_start = 0; s = 0;
    end else if (pclk) begin
      if (!busy) begin
        if (vsync) begin
          if (frame_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
          else begin
            cur = frame_q.pop_front();
            check("frame_cnt_at_start", frame_cnt, 32'(8'(cur.fc)));
            busy = 1; s = 0;
            frames_started++;
          end
        end else begin
          if (must_start) check("chained_restart_vsync", vsync, 32'd1);
          check("idle_outputs", {href, data}, 32'd0);
        end
        must_start = 0;
      end
      if (busy) begin
        line = s / LINE_B;
        bpos = s % LINE_B;
        check("vsync", vsync, 32'(line < VS));
        check("href", href, 32'(line >= VS + VB && line < VS + VB + VA && bpos < 2 * HA));
        if (href) begin
          if (byte_q.size() == 0) check("byte_underflow", 32'd1, 32'd0);
          else check("data", data, byte_q.pop_front());
        end else check("blank_data", data, 32'd0);
        s++;
        if (s == FRAME_B) begin
          busy = 0;
          frames_done++;
          if (frame_q.size() > 0 && frame_q[0].chained) must_start = 1;
        end
      end
    end
  end

  task automatic wait_started(input int n, input int budget);
    int k = 0;
    while (frames_started < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_start_timeout", 32'(frames_started >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_done_timeout", 32'(frames_done >= n), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vsync"}, vsync, 32'd0);
    check({tag, "_href"}, href, 32'd0);
    check({tag, "_data"}, data, 32'd0);
  endtask

  initial begin
    logic prev;
    int   p, k;
    repeat (3) @(negedge clk);
    check("rst_pclk", pclk, 32'd0);
    check_zero("rst");
    check("rst_frame_cnt", frame_cnt, 32'd0);
    rstn = 1'b1;

    prev = pclk;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("pclk_toggle", pclk, 32'(!prev));
      prev = pclk;
      check("idle_frame_cnt", frame_cnt, 32'd0);
    end

    // Colour bars, then a back-to-back checkerboard frame.
    pattern = 2'd0;
    push_frame(0, 1, 1'b0);
    en = 1'b1;
    wait_started(1, FRAME_CLK);
    repeat ($urandom_range(100, 5000)) @(negedge clk);
    pattern = 2'd1;
    push_frame(1, 2, 1'b1);
    wait_started(2, FRAME_CLK + 100);

    // Drop en and change pattern mid-frame: the frame must finish untouched.
    repeat ($urandom_range(100, 5000)) @(negedge clk);
    en = 1'b0;
    pattern = 2'd3;
    wait_done(2, FRAME_CLK + 100);
    repeat (200) @(negedge clk);
    check_zero("idle_after");
    check("idle_after_frame_cnt", frame_cnt, 32'd2);

    // Solid red picked up from the pattern set while the last frame was running.
    push_frame(3, 3, 1'b0);
    en = 1'b1;
    wait_started(3, 100);
    repeat ($urandom_range(100, 5000)) @(negedge clk);
    en = 1'b0;
    pattern = 2'd2;
    wait_done(3, FRAME_CLK + 100);

    // Gradient, chained into a random pattern that is cut by a reset.
    push_frame(2, 4, 1'b0);
    en = 1'b1;
    wait_started(4, 100);
    repeat ($urandom_range(100, 5000)) @(negedge clk);
    p = int'($urandom_range(0, 3));
    pattern = 2'(p);
    push_frame(p, 5, 1'b1);
    wait_started(5, FRAME_CLK + 100);

    k = 0;
    while (!href && k < 8 * LINE_B) begin
      @(negedge clk);
      k++;
    end
    check("href_seen_before_reset", href, 32'd1);
    repeat ($urandom_range(1, 40)) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_pclk", pclk, 32'd0);
    check_zero("async_rst");
    check("async_rst_frame_cnt", frame_cnt, 32'd0);
    repeat (4) @(negedge clk);
    #1 rstn = 1'b1;
    p = int'($urandom_range(0, 3));
    pattern = 2'(p);
    push_frame(p, 1, 1'b0);
    wait_started(6, 100);
    repeat (12 * LINE_B) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
